alu_pipe: RTL and testbench
===========================

# alu_pipe

Registered, parametrised successor to the team's combinational 8-bit ALU. It accepts operations over a valid/ready handshake and holds each result and its flags in an output register until consumed. It adds signed compare, arithmetic shift right, add-with-carry chaining and a multi-cycle unsigned shift-add multiplier. It sits between the operand-fetch stage and writeback in the datapath.

## Interface
- width, 8: operand/result width in bits; any value ≥ 4. `$clog2(width)` sizes the multiply iteration counter.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept this cycle.
- A, B  input  width  operands.
- alu_op  input  4  operation select.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes result this cycle.
- result  output  width  low result word.
- result_hi  output  width  high product word (MUL only, else 0).
- zero, carry, overflow, negative  output  1 each  flags for the held result.

## Operation
- Acceptance: an operation is accepted on an edge where in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SLTU
  - 1000 SRA
  - 1001 SLT (signed)
  - 1010 ADC (A + B + carry_reg)
  - 1011 MUL
  - 1100–1111 reserved: result 0, zero = 1, other flags 0.
- Arithmetic uses width+1-bit intermediates.
  - ADD/ADC: carry = bit width of the sum.
  - SUB: carry = NOT borrow, i.e. 1 when A ≥ B unsigned.
  - Overflow is signed two's-complement overflow for ADD/ADC/SUB only; 0 for all other ops.
- Shifts: shift amount is all of B, unsigned.
  - If B ≥ width: SLL/SRL give 0; SRA gives width copies of A[width-1].
- SLTU/SLT: result is 1 or 0, zero-extended.
- negative = result[width-1].
- zero: for MUL, zero = ({result_hi, result} == 0). For all other ops, zero = (result == 0).
- carry_reg:
  - Internal; updated only by ADD, SUB and ADC, with their carry flag.
  - All other ops leave it unchanged.
  - The flag output carry shows the held op's carry. For MUL, carry = (result_hi != 0); for logic, shift and compare ops, carry = 0.
- MUL is unsigned width×width → 2·width, shift-add with one iteration per clock.
- State machine:
  - IDLE: accepting. A single-cycle op loads the output register on the accept edge. MUL loads the multiplicand, multiplier and zeroed accumulator, and goes to MUL_RUN with the counter at 0.
  - MUL_RUN: one partial-product add and shift per edge. On the edge where counter == width-1, the full product and flags are written to the output register, out_valid is set, and the FSM returns to IDLE. in_ready = 0 throughout.
- Output register:
  - out_valid clears on an edge with out_ready && out_valid unless a new result loads on the same edge.
  - result and flags hold stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; the counter and carry_reg clear.
  - out_valid, result, result_hi and all four flags go to 0.
  - in_ready goes high once rst deasserts.
- Single-cycle ops: out_valid rises after the accept edge (latency 1). Back-to-back ops sustain throughput 1/cycle while out_ready = 1.
- MUL: out_valid rises after the width-th edge following acceptance (8 for width = 8). No new op is accepted until the FSM is back in IDLE. With out_ready held high, the next op is accepted on the edge after out_valid rises.
- Simultaneous consume and accept: the old result retires and the new result loads on the same edge, so out_valid stays 1.
- Reset mid-MUL aborts the multiply with no output produced and clears carry_reg.
- in_valid while in_ready = 0: ignored. The source must hold the op, and no state changes.
- ADC uses the carry_reg value as of the accept edge, including a carry written by the immediately preceding op.

## Test plan
- ADD 7F+01 → result 80, overflow 1, carry 0, negative 1, zero 0; out_valid one cycle after accept. SUB 05−07 → FE, carry 0, negative 1, overflow 0.
- Carry chain: ADD FF+01 → result 00, zero 1, carry 1. Next ADC 00+00 → 01, carry 0. Next ADC 00+00 → 00, zero 1.
- MUL FF×FF → result_hi FE, result 01, carry 1, zero 0. Check out_valid exactly 8 cycles after accept and in_ready = 0 in between. MUL 00×5A → all zeros, zero 1.
- Shifts: SRA 90 by 3 → F2; SRA 90 by 9 → FF; SRL 90 by 9 → 00; SLL 01 by 7 → 80. SLT 80 vs 01 → 1; SLTU 80 vs 01 → 0.
- Backpressure: hold out_ready = 0 after an ADD. Check result and flags stable, in_ready = 0, and a pending op is not accepted. Raise out_ready together with in_valid and check retire-and-accept on one edge.
- Reset: assert rst 3 cycles into a MUL. Check out_valid = 0 and all outputs 0 immediately, with no result appearing later. After reset, ADC 00+00 → 00, confirming carry_reg was cleared.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and result bus for alu_pipe.
//   master (operand-fetch side): drives in_valid, A, B, alu_op, out_ready;
//                                observes in_ready, out_valid, result,
//                                result_hi and the zero/carry/overflow/negative flags.
//   slave  (alu_pipe): the mirror image of master.
interface alu_pipe_if #(
    parameter int width = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] result;
    logic [width-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;

    modport master (
        output in_valid, A, B, alu_op, out_ready,
        input  in_ready, out_valid, result, result_hi,
               zero, carry, overflow, negative
    );

    modport slave (
        input  in_valid, A, B, alu_op, out_ready,
        output in_ready, out_valid, result, result_hi,
               zero, carry, overflow, negative
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake.
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - alu_pipe_if.slave: operation in (in_valid/in_ready, A, B, alu_op),
//          held result out (out_valid/out_ready, result, result_hi, flags).
// Single-cycle ops load the output register on the accept edge. MUL is an
// unsigned shift-add multiplier running one partial product per clock.
module alu_pipe #(
    parameter int width = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MUL_RUN = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic               carry_reg;
    logic [width-1:0]   mcand;
    logic [width-1:0]   mplier;
    logic [2*width-1:0] acc;

    logic [width-1:0]   res_q;
    logic [width-1:0]   res_hi_q;
    logic               valid_q;
    logic               zero_q;
    logic               carry_q;
    logic               ovf_q;
    logic               neg_q;

    logic               accept;

    // single-cycle datapath
    logic [width:0]     add_sum;
    logic [width:0]     sub_diff;
    logic               cin;
    logic [width-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_sets_carry;

    // multiplier step
    logic [width:0]     part_sum;
    logic [2*width-1:0] acc_next;

    assign bus.in_ready  = !rst && (state == IDLE) && (!valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = valid_q;
    assign bus.result    = res_q;
    assign bus.result_hi = res_hi_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;

    always_comb begin
        cin      = (bus.alu_op == OP_ADC) ? carry_reg : 1'b0;
        add_sum  = {1'b0, bus.A} + {1'b0, bus.B} + {{width{1'b0}}, cin};
        sub_diff = {1'b0, bus.A} - {1'b0, bus.B};

        alu_res        = '0;
        alu_c          = 1'b0;
        alu_v          = 1'b0;
        alu_sets_carry = 1'b0;

        unique case (bus.alu_op)
            OP_ADD, OP_ADC: begin
                alu_res        = add_sum[width-1:0];
                alu_c          = add_sum[width];
                alu_v          = (bus.A[width-1] == bus.B[width-1]) &&
                                 (alu_res[width-1] != bus.A[width-1]);
                alu_sets_carry = 1'b1;
            end
            OP_SUB: begin
                alu_res        = sub_diff[width-1:0];
                alu_c          = ~sub_diff[width];
                alu_v          = (bus.A[width-1] != bus.B[width-1]) &&
                                 (alu_res[width-1] != bus.A[width-1]);
                alu_sets_carry = 1'b1;
            end
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            // Shift amounts >= width fall out of the language semantics:
            // logical shifts give 0, arithmetic right fills with the sign.
            OP_SLL:  alu_res = bus.A << bus.B;
            OP_SRL:  alu_res = bus.A >> bus.B;
            OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> bus.B);
            OP_SLTU: alu_res[0] = (bus.A < bus.B);
            OP_SLT:  alu_res[0] = ($signed(bus.A) < $signed(bus.B));
            default: alu_res = '0;
        endcase
    end

    // Accumulator high half absorbs the partial product; the combined word
    // shifts right so product bits collect from the top down.
    always_comb begin
        part_sum = {1'b0, acc[2*width-1:width]} + {1'b0, (mplier[0] ? mcand : {width{1'b0}})};
        acc_next = (2*width)'({part_sum, acc[width-1:0]} >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_reg <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            res_hi_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else if (accept) begin
            if (bus.alu_op == OP_MUL) begin
                mcand   <= bus.A;
                mplier  <= bus.B;
                acc     <= '0;
                cnt     <= '0;
                state   <= MUL_RUN;
                valid_q <= 1'b0;
            end else begin
                valid_q  <= 1'b1;
                res_q    <= alu_res;
                res_hi_q <= '0;
                zero_q   <= (alu_res == '0);
                carry_q  <= alu_c;
                ovf_q    <= alu_v;
                neg_q    <= alu_res[width-1];
                if (alu_sets_carry) begin
                    carry_reg <= alu_c;
                end
            end
        end else if (state == MUL_RUN) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            if (cnt == CNT_LAST) begin
                state    <= IDLE;
                valid_q  <= 1'b1;
                res_q    <= acc_next[width-1:0];
                res_hi_q <= acc_next[2*width-1:width];
                zero_q   <= (acc_next == '0);
                carry_q  <= (acc_next[2*width-1:width] != '0);
                ovf_q    <= 1'b0;
                neg_q    <= acc_next[width-1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (width = 8).
module tb_alu_pipe;
    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   failed;

    alu_pipe_if #(.width(8)) bus ();

    alu_pipe #(.width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, carry, overflow, negative}
    task automatic expect_out(input string tag, input logic [7:0] res,
                              input logic [7:0] hi, input logic [3:0] f);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"}, 32'(bus.result), 32'(res));
        chk({tag, "_hi"}, 32'(bus.result_hi), 32'(hi));
        chk({tag, "_flags"}, 32'({bus.zero, bus.carry, bus.overflow, bus.negative}), 32'(f));
    endtask

    // Present one op, let it be accepted on the next edge, sample #1 later.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        total  = 0;
        passed = 0;
        failed = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.alu_op   = '0;
        bus.out_ready = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", 32'({bus.result_hi, bus.result}), 32'd0);
        chk("rst_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.negative}), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // arithmetic, back-to-back at one op per cycle
        issue(4'b0000, 8'h7F, 8'h01);
        expect_out("add_7f_01", 8'h80, 8'h00, 4'b0011);
        issue(4'b0001, 8'h05, 8'h07);
        expect_out("sub_05_07", 8'hFE, 8'h00, 4'b0001);
        issue(4'b0000, 8'hFF, 8'h01);
        expect_out("add_ff_01", 8'h00, 8'h00, 4'b1100);
        issue(4'b1010, 8'h00, 8'h00);
        expect_out("adc_1", 8'h01, 8'h00, 4'b0000);
        issue(4'b1010, 8'h00, 8'h00);
        expect_out("adc_2", 8'h00, 8'h00, 4'b1000);

        // logic ops
        issue(4'b0010, 8'hF0, 8'h3C);
        expect_out("and", 8'h30, 8'h00, 4'b0000);
        issue(4'b0011, 8'hF0, 8'h0C);
        expect_out("or", 8'hFC, 8'h00, 4'b0001);
        issue(4'b0100, 8'hFF, 8'h0F);
        expect_out("xor", 8'hF0, 8'h00, 4'b0001);

        // shifts and compares
        issue(4'b1000, 8'h90, 8'd3);
        expect_out("sra_3", 8'hF2, 8'h00, 4'b0001);
        issue(4'b1000, 8'h90, 8'd9);
        expect_out("sra_9", 8'hFF, 8'h00, 4'b0001);
        issue(4'b0110, 8'h90, 8'd9);
        expect_out("srl_9", 8'h00, 8'h00, 4'b1000);
        issue(4'b0101, 8'h01, 8'd7);
        expect_out("sll_7", 8'h80, 8'h00, 4'b0001);
        issue(4'b1001, 8'h80, 8'h01);
        expect_out("slt", 8'h01, 8'h00, 4'b0000);
        issue(4'b0111, 8'h80, 8'h01);
        expect_out("sltu", 8'h00, 8'h00, 4'b1000);
        issue(4'b1100, 8'hFF, 8'hFF);
        expect_out("reserved", 8'h00, 8'h00, 4'b1000);

        // consumed with nothing new: out_valid drops
        tick();
        chk("idle_valid_drop", 32'(bus.out_valid), 32'd0);

        // MUL latency: out_valid rises after the 8th edge following accept
        issue(4'b1011, 8'hFF, 8'hFF);
        chk("mul_e0_valid", 32'(bus.out_valid), 32'd0);
        chk("mul_e0_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("mul_e%0d_valid", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("mul_e%0d_ready", i), 32'(bus.in_ready), 32'd0);
        end
        tick();
        expect_out("mul_ff_ff", 8'h01, 8'hFE, 4'b0100);
        chk("mul_done_ready", 32'(bus.in_ready), 32'd1);

        issue(4'b1011, 8'h00, 8'h5A);
        repeat (7) tick();
        chk("mul0_pre_valid", 32'(bus.out_valid), 32'd0);
        tick();
        expect_out("mul_00_5a", 8'h00, 8'h00, 4'b1000);
        tick();

        // backpressure: hold result, block a pending op, then retire-and-accept
        bus.out_ready = 1'b0;
        issue(4'b0000, 8'h12, 8'h34);
        expect_out("bp_add", 8'h46, 8'h00, 4'b0000);
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'b0100;
        bus.A        = 8'hFF;
        bus.B        = 8'h0F;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        expect_out("bp_hold", 8'h46, 8'h00, 4'b0000);
        chk("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        expect_out("bp_retire_accept", 8'hF0, 8'h00, 4'b0001);
        tick();
        chk("bp_final_drop", 32'(bus.out_valid), 32'd0);

        // reset mid-MUL, with carry_reg set beforehand
        issue(4'b0000, 8'hFF, 8'h01);
        expect_out("pre_rst_add", 8'h00, 8'h00, 4'b1100);
        issue(4'b1011, 8'hFF, 8'hFF);
        tick();
        tick();
        tick();
        chk("mid_mul_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_res", 32'({bus.result_hi, bus.result}), 32'd0);
        chk("async_rst_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.negative}), 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("no_result_after_abort", 32'(seen), 32'd0);
        issue(4'b1010, 8'h00, 8'h00);
        expect_out("adc_after_rst", 8'h00, 8'h00, 4'b1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
